// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer.
// Optional stall counter: define PIPE_STATS_EN to enable stall_cnt.
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 3,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [STAT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              xin;

   assign xin = in_valid && in_ready;

   // Occupancy FSM; ready/valid/occupancy are registered per transition
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         occupancy <= 2'd0;
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (flush) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (xin) begin
                  main_data <= in_data;
                  main_ctrl <= in_ctrl;
                  state     <= ONE;
                  out_valid <= 1'b1;
                  occupancy <= 2'd1;
               end
            end
            ONE: begin
               if (xin && out_ready) begin
                  main_data <= in_data;
                  main_ctrl <= in_ctrl;
               end else if (xin) begin
                  skid_data <= in_data;
                  skid_ctrl <= in_ctrl;
                  state     <= FULL;
                  in_ready  <= 1'b0;
                  occupancy <= 2'd2;
               end else if (out_ready) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  occupancy <= 2'd0;
               end
            end
            FULL: begin
               if (out_ready) begin
                  main_data <= skid_data;
                  main_ctrl <= skid_ctrl;
                  state     <= ONE;
                  in_ready  <= 1'b1;
                  occupancy <= 2'd1;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               occupancy <= 2'd0;
            end
         endcase
      end
   end

   // Bubbles never carry control bits downstream
   assign out_data = main_data;
   assign out_ctrl = out_valid ? main_ctrl : '0;

`ifdef PIPE_STATS_EN
   logic [STAT_W-1:0] stall_q;

   // Saturating back-pressure counter; only reset clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, skid,
// flush, bubble masking and stall counter saturation.
module tb_pipe_stage_skid;

   localparam int DW = 32;
   localparam int CW = 3;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic [SW-1:0] stall_cnt;

   int n_run  = 0;
   int n_fail = 0;

`ifdef PIPE_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   pipe_stage_skid #(
      .DATA_W(DW),
      .CTRL_W(CW),
      .STAT_W(SW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_ctrl(in_ctrl),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_ctrl(out_ctrl),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_ov"}, 32'(out_valid), 32'd0);
      chk({tag, "_ir"}, 32'(in_ready), 32'd1);
      chk({tag, "_occ"}, 32'(occupancy), 32'd0);
      chk({tag, "_ctl"}, 32'(out_ctrl), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h55;
      in_ctrl = 3'b111;
      out_ready = 1'b0;

      // 1. reset with in_valid high
      tick();
      chk_empty("rst1");
      chk("rst1_stall", 32'(stall_cnt), 32'd0);
      tick();
      chk_empty("rst2");
      chk("rst2_data", out_data, 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      chk_empty("rel");
      tick();
      chk_empty("rel1");

      // 2. streaming
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_ctrl = 3'b010;
      for (int i = 0; i < 5; i++) begin
         in_data = 32'h100 + 32'(i);
         tick();
         chk("str_ov", 32'(out_valid), 32'd1);
         chk("str_data", out_data, 32'h100 + 32'(i));
         chk("str_ctl", 32'(out_ctrl), 32'd2);
         chk("str_occ", 32'(occupancy), 32'd1);
         chk("str_ir", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk_empty("str_end");
      chk("str_hold", out_data, 32'h104);

      // 3. back-pressure into skid
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_ctrl = 3'b001;
      in_data = 32'hA;
      tick();
      chk("bp_occ1", 32'(occupancy), 32'd1);
      in_data = 32'hB;
      tick();
      chk("bp_occ2", 32'(occupancy), 32'd2);
      chk("bp_ir", 32'(in_ready), 32'd0);
      chk("bp_a", out_data, 32'hA);
      in_data = 32'hC;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", out_data, 32'hA);
         chk("bp_hocc", 32'(occupancy), 32'd2);
         chk("bp_hir", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_b", out_data, 32'hB);
      chk("bp_bocc", 32'(occupancy), 32'd1);
      chk("bp_bir", 32'(in_ready), 32'd1);
      tick();
      chk("bp_c", out_data, 32'hC);
      chk("bp_cov", 32'(out_valid), 32'd1);
      chk("bp_cocc", 32'(occupancy), 32'd1);
      in_valid = 1'b0;
      tick();
      chk_empty("bp_end");

      // 4. flush while full
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'hA;
      tick();
      in_data = 32'hB;
      tick();
      chk("fl_full", 32'(occupancy), 32'd2);
      in_data = 32'hC;
      flush = 1'b1;
      tick();
      chk_empty("fl1");
      flush = 1'b0;
      in_valid = 1'b0;
      tick();
      chk_empty("fl2");
      out_ready = 1'b1;
      tick();
      chk_empty("fl3");

      // 5. bubble masking
      in_valid = 1'b1;
      in_data = 32'h77;
      in_ctrl = 3'b111;
      tick();
      chk("bub_ctl", 32'(out_ctrl), 32'd7);
      chk("bub_ov", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      chk_empty("bub");
      chk("bub_data", out_data, 32'h77);

      // 6. stall counter
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("st_rst", 32'(stall_cnt), 32'd0);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h1;
      tick();
      in_valid = 1'b0;
      chk("st_0", 32'(stall_cnt), 32'd0);
      repeat (10) tick();
      chk("st_10", 32'(stall_cnt), STATS ? 32'd10 : 32'd0);
      repeat (10) tick();
      chk("st_sat", 32'(stall_cnt), STATS ? 32'd15 : 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("st_fl", 32'(stall_cnt), STATS ? 32'd15 : 32'd0);
      chk_empty("st_fl");
      tick();
      chk("st_fl2", 32'(stall_cnt), STATS ? 32'd15 : 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("st_clr", 32'(stall_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
